// File: rtl/llc_set_read_if.sv
// ---------------------------------------------------------------------------
// llc_set_read_if
//   Bundles the signals around the LLC set-read stage:
//     - decoder request   : req_valid/req_ready, req_set, req_tag
//     - tag/state SRAM    : sram_rd_en, sram_rd_set, sram_tags, sram_states,
//                           sram_evict_way
//     - way-lookup output : out_valid/out_ready, out_set, out_tag, tags_buf,
//                           states_buf, evict_way_buf
//     - update write-back : wr_en, wr_set, wr_way, wr_tag, wr_state
//     - status            : busy
//   slave  : the set-read stage itself.
//   master : everything around it (decoder, SRAM, lookup, update stage).
// ---------------------------------------------------------------------------
interface llc_set_read_if #(
  parameter int unsigned WAYS     = 16,
  parameter int unsigned WAY_BITS = 4,
  parameter int unsigned SET_BITS = 9,
  parameter int unsigned TAG_BITS = 15,
  parameter int unsigned ST_BITS  = 3
);
  logic                     req_valid;
  logic                     req_ready;
  logic [SET_BITS-1:0]      req_set;
  logic [TAG_BITS-1:0]      req_tag;

  logic                     sram_rd_en;
  logic [SET_BITS-1:0]      sram_rd_set;
  logic [WAYS*TAG_BITS-1:0] sram_tags;
  logic [WAYS*ST_BITS-1:0]  sram_states;
  logic [WAY_BITS-1:0]      sram_evict_way;

  logic                     out_valid;
  logic                     out_ready;
  logic [SET_BITS-1:0]      out_set;
  logic [TAG_BITS-1:0]      out_tag;
  logic [WAYS*TAG_BITS-1:0] tags_buf;
  logic [WAYS*ST_BITS-1:0]  states_buf;
  logic [WAY_BITS-1:0]      evict_way_buf;

  logic                     wr_en;
  logic [SET_BITS-1:0]      wr_set;
  logic [WAY_BITS-1:0]      wr_way;
  logic [TAG_BITS-1:0]      wr_tag;
  logic [ST_BITS-1:0]       wr_state;

  logic                     busy;

  modport slave (
    input  req_valid, req_set, req_tag,
    output req_ready,
    output sram_rd_en, sram_rd_set,
    input  sram_tags, sram_states, sram_evict_way,
    output out_valid, out_set, out_tag, tags_buf, states_buf, evict_way_buf,
    input  out_ready,
    input  wr_en, wr_set, wr_way, wr_tag, wr_state,
    output busy
  );

  modport master (
    output req_valid, req_set, req_tag,
    input  req_ready,
    input  sram_rd_en, sram_rd_set,
    output sram_tags, sram_states, sram_evict_way,
    input  out_valid, out_set, out_tag, tags_buf, states_buf, evict_way_buf,
    output out_ready,
    output wr_en, wr_set, wr_way, wr_tag, wr_state,
    input  busy
  );
endinterface

// File: rtl/llc_set_read.sv
// ---------------------------------------------------------------------------
// llc_set_read
//   LLC set-read stage feeding way-lookup. Accepts one decoded request
//   (set, tag), issues a single tag/state/evict-way SRAM read for the set,
//   captures the returned row into holding buffers and presents it with the
//   request tag over a valid/ready handshake. At most one request in flight.
//
// Ports
//   clk  : clock
//   rst  : asynchronous reset, active low
//   bus  : llc_set_read_if.slave (request, SRAM, lookup output, write-back,
//          busy)
//
// Parameters
//   WAYS, WAY_BITS, SET_BITS, TAG_BITS, ST_BITS : geometry (must match bus)
//   RD_LAT : SRAM read latency in cycles, 1..3
//
// Build option
//   LLC_SET_READ_BYPASS_EN : when defined, write-backs to the in-flight set
//   are merged into the captured row (pending patches during READ, direct
//   buffer update in FULL). When undefined, the wr_* inputs are ignored.
// ---------------------------------------------------------------------------
module llc_set_read #(
  parameter int unsigned WAYS     = 16,
  parameter int unsigned WAY_BITS = 4,
  parameter int unsigned SET_BITS = 9,
  parameter int unsigned TAG_BITS = 15,
  parameter int unsigned ST_BITS  = 3,
  parameter int unsigned RD_LAT   = 1
) (
  input logic          clk,
  input logic          rst,
  llc_set_read_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  logic [1:0]               state_q, state_d;
  logic [1:0]               lat_q, lat_d;
  logic [SET_BITS-1:0]      set_q, set_d;
  logic [TAG_BITS-1:0]      tag_q, tag_d;
  logic [WAYS*TAG_BITS-1:0] tags_q, tags_d;
  logic [WAYS*ST_BITS-1:0]  states_q, states_d;
  logic [WAY_BITS-1:0]      evict_q, evict_d;

  logic                     req_ready;
  logic                     accept;
  logic                     capture;

  // Row as it will be captured (SRAM merged with any patches) and buffers as
  // they will look after a FULL-state write-back.
  logic [WAYS*TAG_BITS-1:0] cap_tags;
  logic [WAYS*ST_BITS-1:0]  cap_states;
  logic [WAYS*TAG_BITS-1:0] upd_tags;
  logic [WAYS*ST_BITS-1:0]  upd_states;

  // A new request is taken only when idle, or when the current result is
  // being consumed in the same cycle.
  always_comb begin
    req_ready = (state_q == IDLE) || ((state_q == FULL) && bus.out_ready);
    accept    = bus.req_valid && req_ready;
    capture   = (state_q == READ) && (lat_q == LAT_LAST);
  end

  assign bus.req_ready     = req_ready;
  assign bus.sram_rd_en    = accept;
  assign bus.sram_rd_set   = accept ? bus.req_set : set_q;
  assign bus.out_valid     = (state_q == FULL);
  assign bus.busy          = (state_q != IDLE);
  assign bus.out_set       = set_q;
  assign bus.out_tag       = tag_q;
  assign bus.tags_buf      = tags_q;
  assign bus.states_buf    = states_q;
  assign bus.evict_way_buf = evict_q;

`ifdef LLC_SET_READ_BYPASS_EN
  logic [WAYS-1:0]          pmask_q, pmask_d, pmask_nxt;
  logic [WAYS*TAG_BITS-1:0] ptag_q, ptag_d, ptag_nxt;
  logic [WAYS*ST_BITS-1:0]  pst_q, pst_d, pst_nxt;
  logic [SET_BITS-1:0]      patch_set;
  logic                     patch_wr;
  logic                     full_wr;

  // The set being read is req_set in the accept cycle and set_q afterwards.
  // A write landing in the capture cycle is folded into the merge directly,
  // so it is not lost when the patches clear on that same edge.
  always_comb begin
    patch_set  = accept ? bus.req_set : set_q;
    patch_wr   = bus.wr_en && (accept || (state_q == READ)) &&
                 (bus.wr_set == patch_set);
    full_wr    = bus.wr_en && (state_q == FULL) && (bus.wr_set == set_q);
    pmask_nxt  = pmask_q;
    ptag_nxt   = ptag_q;
    pst_nxt    = pst_q;
    cap_tags   = bus.sram_tags;
    cap_states = bus.sram_states;
    upd_tags   = tags_q;
    upd_states = states_q;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (patch_wr && (bus.wr_way == WAY_BITS'(w))) begin
        pmask_nxt[w]                          = 1'b1;
        ptag_nxt[w*TAG_BITS +: TAG_BITS]      = bus.wr_tag;
        pst_nxt[w*ST_BITS +: ST_BITS]         = bus.wr_state;
      end
      if (full_wr && (bus.wr_way == WAY_BITS'(w))) begin
        upd_tags[w*TAG_BITS +: TAG_BITS]      = bus.wr_tag;
        upd_states[w*ST_BITS +: ST_BITS]      = bus.wr_state;
      end
      if (pmask_nxt[w]) begin
        cap_tags[w*TAG_BITS +: TAG_BITS]      = ptag_nxt[w*TAG_BITS +: TAG_BITS];
        cap_states[w*ST_BITS +: ST_BITS]      = pst_nxt[w*ST_BITS +: ST_BITS];
      end
    end
    pmask_d = capture ? '0 : pmask_nxt;
    ptag_d  = ptag_nxt;
    pst_d   = pst_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmask_q <= '0;
      ptag_q  <= '0;
      pst_q   <= '0;
    end else begin
      pmask_q <= pmask_d;
      ptag_q  <= ptag_d;
      pst_q   <= pst_d;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{bus.wr_en, bus.wr_set, bus.wr_way, bus.wr_tag,
                       bus.wr_state};

  always_comb begin
    cap_tags   = bus.sram_tags;
    cap_states = bus.sram_states;
    upd_tags   = tags_q;
    upd_states = states_q;
  end
`endif

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    set_d    = set_q;
    tag_d    = tag_q;
    tags_d   = tags_q;
    states_d = states_q;
    evict_d  = evict_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = READ;
          lat_d   = '0;
          set_d   = bus.req_set;
          tag_d   = bus.req_tag;
        end
      end
      READ: begin
        if (capture) begin
          state_d  = FULL;
          tags_d   = cap_tags;
          states_d = cap_states;
          evict_d  = bus.sram_evict_way;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      FULL: begin
        tags_d   = upd_tags;
        states_d = upd_states;
        if (bus.out_ready) begin
          if (accept) begin
            state_d = READ;
            lat_d   = '0;
            set_d   = bus.req_set;
            tag_d   = bus.req_tag;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      set_q    <= '0;
      tag_q    <= '0;
      tags_q   <= '0;
      states_q <= '0;
      evict_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      set_q    <= set_d;
      tag_q    <= tag_d;
      tags_q   <= tags_d;
      states_q <= states_d;
      evict_q  <= evict_d;
    end
  end

endmodule
